mc_datapath_hs: RTL and testbench

- Parametrised next-generation multicycle datapath for the 16-bit-instruction RISC-V-style core.
- Data width is generalised (XLEN), and register-zero hardwiring is optional.
- Unlike the previous datapath, memory is external behind a req/ack handshake with arbitrary wait states, so the controller is stalled by a built-in memory sequencer FSM.
- Sits between the main controller FSM and the shared instruction/data memory.

---
 rtl/mc_datapath_hs_if.sv | 56 +++++
 rtl/mc_datapath_hs.sv | 189 ++++++++++++++++++
 tb/tb_mc_datapath_hs.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_hs_if.sv
// ============================================================================
// mc_datapath_hs_if : controller / memory bundle for the multicycle datapath
// Rev 1.0
// ============================================================================
`default_nettype none

interface mc_datapath_hs_if #(
    parameter int XLEN = 16,
    parameter int AW   = 8
);
    logic             pc_write;
    logic             adr_src;
    logic             ir_write;
    logic             mem_start;
    logic             mem_wr;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctl;
    logic [1:0]       imm_src;
    logic [2:0]       op;
    logic [2:0]       func3;
    logic             funct7;
    logic [1:0]       branch_funct;
    logic             zero;
    logic             lt;
    logic             mem_busy;
    logic             mem_done;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  mem_rdata;
    logic             mem_ack;

    // Controller plus memory side
    modport master (
        output pc_write, adr_src, ir_write, mem_start, mem_wr, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_ctl, imm_src,
        input  op, func3, funct7, branch_funct, zero, lt, mem_busy, mem_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    // Datapath side
    modport slave (
        input  pc_write, adr_src, ir_write, mem_start, mem_wr, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_ctl, imm_src,
        output op, func3, funct7, branch_funct, zero, lt, mem_busy, mem_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mc_datapath_hs.sv
// ============================================================================
// mc_datapath_hs : multicycle datapath with req/ack memory sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_datapath_hs #(
    parameter int XLEN    = 16,
    parameter int AW      = 8,
    parameter int R0_ZERO = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mc_datapath_hs_if.slave    bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    seq_state_t       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             fetch_q, fetch_d;
    logic             accept, ack_rx;

    logic [XLEN-1:0]  pc_q, oldpc_q, mdr_q, a_q, b_q, aluout_q;
    logic [15:0]      ir_q;
    logic [XLEN-1:0]  rf_q [8];

    logic [2:0]       rd, rs1, rs2;
    logic [XLEN-1:0]  rs1_val, rs2_val, imm_ext, src_a, src_b, alu_result, result;
    logic             lt_w, rf_we;

    assign rd  = ir_q[11:9];
    assign rs2 = ir_q[8:6];
    assign rs1 = ir_q[5:3];

    assign bus.op           = ir_q[14:12];
    assign bus.func3        = ir_q[2:0];
    assign bus.funct7       = ir_q[15];
    assign bus.branch_funct = ir_q[11:10];

    generate
        if (R0_ZERO != 0) begin : g_r0_zero
            assign rs1_val = (rs1 == 3'd0) ? '0 : rf_q[rs1];
            assign rs2_val = (rs2 == 3'd0) ? '0 : rf_q[rs2];
            assign rf_we   = bus.reg_write && (rd != 3'd0);
        end else begin : g_r0_reg
            assign rs1_val = rf_q[rs1];
            assign rs2_val = rf_q[rs2];
            assign rf_we   = bus.reg_write;
        end
    endgenerate

    always_comb begin
        imm_ext = '0;
        case (bus.imm_src)
            2'b00:   imm_ext = {{(XLEN-6){ir_q[5]}}, ir_q[5:0]};
            2'b01:   imm_ext = {{(XLEN-9){ir_q[8]}}, ir_q[8:0]};
            2'b10:   imm_ext = {{(XLEN-13){ir_q[15]}}, ir_q[15], ir_q[11:0]};
            default: imm_ext = {{(XLEN-12){1'b0}}, ir_q[11:0]};
        endcase
    end

    always_comb begin
        src_a = '0;
        case (bus.alu_src_a)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = oldpc_q;
            2'b10:   src_a = a_q;
            default: src_a = '0;
        endcase
        src_b = '0;
        case (bus.alu_src_b)
            2'b00:   src_b = b_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = XLEN'(2);
            default: src_b = '0;
        endcase
    end

    assign lt_w = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu_result = '0;
        case (bus.alu_ctl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, lt_w};
            3'b110:  alu_result = src_a << src_b[SHW-1:0];
            default: alu_result = src_a >> src_b[SHW-1:0];
        endcase
    end

    assign bus.zero = (alu_result == '0);
    assign bus.lt   = lt_w;

    always_comb begin
        result = '0;
        case (bus.result_src)
            2'b00:   result = aluout_q;
            2'b01:   result = mdr_q;
            2'b10:   result = alu_result;
            default: result = imm_ext;
        endcase
    end

    // Sequencer: address, data and direction are captured once at start and held
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        accept  = 1'b0;
        ack_rx  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_start) begin
                    accept  = 1'b1;
                    addr_d  = bus.adr_src ? result[AW-1:0] : pc_q[AW-1:0];
                    wdata_d = b_q;
                    we_d    = bus.mem_wr;
                    fetch_d = bus.ir_write;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    ack_rx  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_busy  = (state_q != S_IDLE);
    assign bus.mem_done  = (state_q == S_DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            fetch_q  <= 1'b0;
            pc_q     <= '0;
            oldpc_q  <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            fetch_q  <= fetch_d;
            a_q      <= rs1_val;
            b_q      <= rs2_val;
            aluout_q <= alu_result;
            if (bus.pc_write) pc_q <= result;
            if (accept && bus.ir_write) oldpc_q <= pc_q;
            if (ack_rx && !we_q) begin
                mdr_q <= bus.mem_rdata;
                if (fetch_q) ir_q <= bus.mem_rdata[15:0];
            end
            if (rf_we) rf_q[rd] <= result;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mc_datapath_hs.sv
// ============================================================================
// tb_mc_datapath_hs : directed bench, 16-bit and 32-bit datapaths in lockstep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_datapath_hs;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0, adr_src = 1'b0, ir_write = 1'b0;
    logic        mem_start = 1'b0, mem_wr = 1'b0, reg_write = 1'b0, mem_ack = 1'b0;
    logic [1:0]  result_src = 2'b00, alu_src_a = 2'b00, alu_src_b = 2'b00, imm_src = 2'b00;
    logic [2:0]  alu_ctl = 3'b000;
    logic [31:0] rdata = 32'h0;

    int          n_checks = 0;
    int          n_pass   = 0;

    int          acc_req, acc_busy, acc_done_at;
    logic        acc_stable, acc_we;
    logic [7:0]  acc_addr;
    logic [15:0] acc_wdata;

    always #5 clk = ~clk;

    mc_datapath_hs_if #(.XLEN(16), .AW(8)) if16 ();
    mc_datapath_hs_if #(.XLEN(32), .AW(8)) if32 ();

    assign if16.pc_write = pc_write;     assign if32.pc_write = pc_write;
    assign if16.adr_src = adr_src;       assign if32.adr_src = adr_src;
    assign if16.ir_write = ir_write;     assign if32.ir_write = ir_write;
    assign if16.mem_start = mem_start;   assign if32.mem_start = mem_start;
    assign if16.mem_wr = mem_wr;         assign if32.mem_wr = mem_wr;
    assign if16.reg_write = reg_write;   assign if32.reg_write = reg_write;
    assign if16.result_src = result_src; assign if32.result_src = result_src;
    assign if16.alu_src_a = alu_src_a;   assign if32.alu_src_a = alu_src_a;
    assign if16.alu_src_b = alu_src_b;   assign if32.alu_src_b = alu_src_b;
    assign if16.alu_ctl = alu_ctl;       assign if32.alu_ctl = alu_ctl;
    assign if16.imm_src = imm_src;       assign if32.imm_src = imm_src;
    assign if16.mem_ack = mem_ack;       assign if32.mem_ack = mem_ack;
    assign if16.mem_rdata = rdata[15:0]; assign if32.mem_rdata = rdata;

    mc_datapath_hs #(.XLEN(16), .AW(8), .R0_ZERO(1)) d16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    mc_datapath_hs #(.XLEN(32), .AW(8), .R0_ZERO(1)) d32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Entered and left one time unit after a rising edge
    task automatic access(input logic fetch, input logic wr, input logic asrc,
                          input int waits, input logic [31:0] data, input logic inject);
        acc_req = 0; acc_busy = 0; acc_done_at = -1; acc_stable = 1'b1;
        mem_start = 1'b1; ir_write = fetch; mem_wr = wr; adr_src = asrc;
        @(posedge clk); #1;
        mem_start = 1'b0; ir_write = 1'b0; mem_wr = 1'b0;
        for (int c = 1; c <= waits + 4; c++) begin
            mem_ack   = (c == waits + 1);
            rdata     = data;
            mem_start = inject && (c == 1);
            if (inject && c == 1) adr_src = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                acc_addr  = if16.mem_addr;
                acc_we    = if16.mem_we;
                acc_wdata = if16.mem_wdata;
            end
            if (if16.mem_req) acc_req++;
            if (if16.mem_busy) acc_busy++;
            if (if16.mem_req && if16.mem_addr != acc_addr) acc_stable = 1'b0;
            if (if16.mem_done && acc_done_at < 0) acc_done_at = c;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; mem_start = 1'b0; adr_src = 1'b0;
    endtask

    task automatic ctl_cycle(input logic pcw, input logic rw, input logic [1:0] rsrc, input logic [1:0] isrc);
        pc_write = pcw; reg_write = rw; result_src = rsrc; imm_src = isrc;
        @(posedge clk); #1;
        pc_write = 1'b0; reg_write = 1'b0; result_src = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic alu_eval(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ctl);
        alu_src_a = sa; alu_src_b = sb; alu_ctl = ctl;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req",  {31'b0, if16.mem_req},  32'h0);
        check_val("rst_busy", {31'b0, if16.mem_busy}, 32'h0);
        check_val("rst_done", {31'b0, if16.mem_done}, 32'h0);
        check_val("rst_pc",   d16.pc_q,  32'h0);
        check_val("rst_ir",   d16.ir_q,  32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Bring PC to 4 through the immediate of a first fetched word
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0004, 1'b0);
        ctl_cycle(1'b1, 1'b0, 2'b11, 2'b00);
        check_val("pc_load", d16.pc_q, 32'h4);

        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_1234, 1'b0);
        check_val("fetch_addr",  acc_addr, 32'h04);
        check_val("fetch_req",   acc_req, 32'd1);
        check_val("fetch_done",  acc_done_at, 32'd2);
        check_val("fetch_ir",    d16.ir_q, 32'h1234);
        check_val("fetch_oldpc", d16.oldpc_q, 32'h4);
        check_val("dec_op",      {29'b0, if16.op}, 32'h1);
        check_val("dec_func3",   {29'b0, if16.func3}, 32'h4);

        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0920, 1'b0);
        access(1'b0, 1'b0, 1'b0, 5, 32'h0000_BEEF, 1'b0);
        check_val("wait_req",    acc_req, 32'd6);
        check_val("wait_busy",   acc_busy, 32'd7);
        check_val("wait_stable", {31'b0, acc_stable}, 32'h1);
        check_val("wait_done",   acc_done_at, 32'd7);
        check_val("wait_mdr",    d16.mdr_q, 32'hBEEF);
        check_val("wait_ir",     d16.ir_q, 32'h0920);

        ctl_cycle(1'b0, 1'b1, 2'b01, 2'b00);
        check_val("rf4", d16.rf_q[4], 32'hBEEF);
        result_src = 2'b11; imm_src = 2'b11;
        access(1'b0, 1'b1, 1'b1, 2, 32'h0000_5A5A, 1'b1);
        result_src = 2'b00; imm_src = 2'b00;
        check_val("wr_we",     {31'b0, acc_we}, 32'h1);
        check_val("wr_wdata",  acc_wdata, 32'hBEEF);
        check_val("wr_addr",   acc_addr, 32'h20);
        check_val("wr_stable", {31'b0, acc_stable}, 32'h1);
        check_val("wr_busy",   acc_busy, 32'd4);
        check_val("wr_mdr",    d16.mdr_q, 32'hBEEF);

        // r1 = 0x8000 (from MDR), r2 = 3 (from immediate)
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0200, 1'b0);
        access(1'b0, 1'b0, 1'b0, 0, 32'h0000_8000, 1'b0);
        ctl_cycle(1'b0, 1'b1, 2'b01, 2'b00);
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0403, 1'b0);
        ctl_cycle(1'b0, 1'b1, 2'b11, 2'b00);
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0088, 1'b0);
        alu_eval(2'b10, 2'b00, 3'b101);
        check_val("slt",      d16.alu_result, 32'h1);
        check_val("slt_lt",   {31'b0, if16.lt}, 32'h1);
        check_val("slt_zero", {31'b0, if16.zero}, 32'h0);
        alu_eval(2'b10, 2'b00, 3'b111);
        check_val("srl",      d16.alu_result, 32'h1000);
        alu_eval(2'b10, 2'b00, 3'b100);
        check_val("xor",      d16.alu_result, 32'h8003);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0093, 1'b0);
        alu_eval(2'b10, 2'b00, 3'b001);
        check_val("sub_zero", {31'b0, if16.zero}, 32'h1);
        @(posedge clk); #1;

        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0055, 1'b0);
        imm_src = 2'b01;
        #1 check_val("imm01", d16.imm_ext, 32'h0055);
        ctl_cycle(1'b0, 1'b1, 2'b11, 2'b01);
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0);
        check_val("r0_a", d16.a_q, 32'h0);
        alu_eval(2'b10, 2'b00, 3'b000);
        check_val("r0_zero", {31'b0, if16.zero}, 32'h1);
        @(posedge clk); #1;

        // Width: r1 = 1, r7 = 0x7FFFFFFF on the 32-bit datapath
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0201, 1'b0);
        ctl_cycle(1'b0, 1'b1, 2'b11, 2'b00);
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_8FFF, 1'b0);
        imm_src = 2'b10;
        #1 check_val("imm10_32", d32.imm_ext, 32'hFFFF_FFFF);
        check_val("imm10_16", d16.imm_ext, 32'h0000_FFFF);
        access(1'b0, 1'b0, 1'b0, 0, 32'h7FFF_FFFF, 1'b0);
        ctl_cycle(1'b0, 1'b1, 2'b01, 2'b00);
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_0078, 1'b0);
        alu_eval(2'b10, 2'b00, 3'b000);
        check_val("add32",      d32.alu_result, 32'h8000_0000);
        check_val("add32_lt",   {31'b0, if32.lt}, 32'h0);
        check_val("add16_wrap", {31'b0, if16.zero}, 32'h1);
        @(posedge clk); #1;

        // Reset while a read is waiting for ack
        mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0;
        @(negedge clk);
        check_val("pre_rst_req", {31'b0, if16.mem_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_req",  {31'b0, if16.mem_req}, 32'h0);
        check_val("mid_rst_busy", {31'b0, if16.mem_busy}, 32'h0);
        check_val("mid_rst_ir",   d16.ir_q, 32'h0);
        check_val("mid_rst_rf1",  d16.rf_q[1], 32'h0);
        check_val("mid_rst_mdr",  d32.mdr_q, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 1'b0, 0, 32'h0000_00AB, 1'b0);
        check_val("post_rst_req",  acc_req, 32'd1);
        check_val("post_rst_addr", acc_addr, 32'h00);
        check_val("post_rst_ir",   d16.ir_q, 32'h00AB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
